// File: rtl/ahb_isp_sys.sv
`timescale 1ns/1ps
// ahb_isp_sys: AHB-Lite configured Bayer-to-RGB565 pixel path.
// Classifies each incoming Bayer pixel, applies a per-colour white-balance gain,
// keeps the last R/G/B sample and emits packed RGB565 two edges after latching.
module ahb_isp_sys #(
  parameter int unsigned LPF_W  = 10,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [31:0]       HADDR,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic              HSEL,
  input  logic [2:0]        HSIZE,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  input  logic [15:0]       data_in,
  input  logic              fifo_empty,
  output logic [15:0]       rgb_data_out,
  output logic              DoutEn,
  output logic [FCNT_W-1:0] frames_cnt
);

  localparam logic [2:0] AddrCtrl = 3'd0;
  localparam logic [2:0] AddrWb   = 3'd1;
  localparam logic [2:0] AddrFrm  = 3'd2;
  localparam logic [2:0] AddrCfg  = 3'd3;
  localparam logic [2:0] AddrStat = 3'd4;

  typedef enum logic [1:0] {ColR = 2'd0, ColG = 2'd1, ColB = 2'd2} colour_e;

  // Bus-side state
  logic        addr_acc;
  logic        dph_vld_q, dph_write_q;
  logic [2:0]  dph_addr_q;
  logic        reg_we, frm_clr;

  // Configuration registers
  logic        byp_q, en_q;
  logic [31:0] wb_q, frm_q;
  logic [1:0]  cfg_q;

  // Line / frame tracking
  logic              accept, line_end, frame_end;
  logic              prev_acc_q, prev_acc_d;
  logic              x_q, x_d, y_q, y_d;
  logic [LPF_W-1:0]  line_q, line_d;
  logic [FCNT_W-1:0] frames_q, frames_d;
  logic [LPF_W-1:0]  lpf;
  logic [LPF_W:0]    lpf_eff, line_nxt;

  // Pixel classification
  logic    pix_x, pix_is_g, pix_is_r;
  colour_e pix_col;
  logic [7:0] pix_gain;

  // Pipeline stages
  logic        s1_vld_q, s1_byp_q, s1_fire;
  logic [11:0] s1_raw_q;
  colour_e     s1_col_q;
  logic [7:0]  s1_gain_q;
  logic [19:0] prod;
  logic [15:0] scaled;
  logic [11:0] sat;
  logic        s2_vld_q, s2_byp_q, s2_fire;
  logic [11:0] s2_raw_q;
  logic [11:0] hold_r_q, hold_g_q, hold_b_q;
  logic [15:0] rgb_q, rgb_d;
  logic        dout_en_q;

  logic unused_ok;
  assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HSIZE, data_in[3:0]};

  assign addr_acc = HSEL & HREADY & HTRANS[1];

  // Latch address-phase attributes for the following data phase
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dph_vld_q   <= 1'b0;
      dph_write_q <= 1'b0;
      dph_addr_q  <= 3'd0;
    end else begin
      dph_vld_q <= addr_acc;
      if (addr_acc) begin
        dph_write_q <= HWRITE;
        dph_addr_q  <= HADDR[4:2];
      end
    end
  end

  assign reg_we  = dph_vld_q & dph_write_q;
  assign frm_clr = reg_we & (dph_addr_q == AddrCtrl) & HWDATA[1];

  // Configuration register writes, using HWDATA of the data phase
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      byp_q <= 1'b0;
      en_q  <= 1'b0;
      wb_q  <= 32'd0;
      frm_q <= 32'd0;
      cfg_q <= 2'd0;
    end else if (reg_we) begin
      case (dph_addr_q)
        AddrCtrl: begin
          byp_q <= HWDATA[0];
          en_q  <= HWDATA[2];
        end
        AddrWb:  wb_q  <= HWDATA;
        AddrFrm: frm_q <= HWDATA;
        AddrCfg: cfg_q <= HWDATA[1:0];
        default: ;
      endcase
    end
  end

  // Read mux; only a read data phase drives non-zero data
  always_comb begin
    HRDATA = 32'd0;
    if (dph_vld_q && !dph_write_q) begin
      case (dph_addr_q)
        AddrCtrl: HRDATA = {29'd0, en_q, 1'b0, byp_q};
        AddrWb:   HRDATA = wb_q;
        AddrFrm:  HRDATA = frm_q;
        AddrCfg:  HRDATA = {30'd0, cfg_q};
        AddrStat: HRDATA = 32'(frames_q);
        default:  HRDATA = 32'd0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;

  assign accept    = en_q & ~fifo_empty;
  assign line_end  = en_q & prev_acc_q & fifo_empty;
  assign lpf       = frm_q[LPF_W-1:0];
  // An LPF field of zero stands for 2**LPF_W lines
  assign lpf_eff   = (lpf == '0) ? {1'b1, {LPF_W{1'b0}}} : {1'b0, lpf};
  assign line_nxt  = {1'b0, line_q} + {{LPF_W{1'b0}}, 1'b1};
  assign frame_end = line_end & (line_nxt == lpf_eff);

  // Next-state for line/column parity, line and frame counters
  always_comb begin
    prev_acc_d = prev_acc_q;
    x_d        = x_q;
    y_d        = y_q;
    line_d     = line_q;
    frames_d   = frames_q;
    if (en_q) begin
      prev_acc_d = ~fifo_empty;
      if (accept) begin
        x_d = ~pix_x;
      end
      if (line_end) begin
        if (frame_end) begin
          line_d   = '0;
          y_d      = 1'b0;
          frames_d = frames_q + {{(FCNT_W-1){1'b0}}, 1'b1};
        end else begin
          line_d = line_nxt[LPF_W-1:0];
          y_d    = ~y_q;
        end
      end
    end
    // A clear coinciding with a frame end takes priority
    if (frm_clr) begin
      frames_d = '0;
    end
  end

  // Tracking state registers
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      prev_acc_q <= 1'b0;
      x_q        <= 1'b0;
      y_q        <= 1'b0;
      line_q     <= '0;
      frames_q   <= '0;
    end else begin
      prev_acc_q <= prev_acc_d;
      x_q        <= x_d;
      y_q        <= y_d;
      line_q     <= line_d;
      frames_q   <= frames_d;
    end
  end

  // First pixel of a line always sits at column parity 0
  assign pix_x    = prev_acc_q & x_q;
  assign pix_is_g = (pix_x ^ y_q) != (cfg_q[0] ^ cfg_q[1]);
  assign pix_is_r = (y_q == cfg_q[1]);

  // Colour classification and gain selection for the incoming pixel
  always_comb begin
    pix_col  = ColB;
    pix_gain = wb_q[23:16];
    if (pix_is_g) begin
      pix_col  = ColG;
      pix_gain = wb_q[15:8];
    end else if (pix_is_r) begin
      pix_col  = ColR;
      pix_gain = wb_q[7:0];
    end
  end

  // Stage 1: capture raw sample with the configuration in force at this edge
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      s1_vld_q  <= 1'b0;
      s1_raw_q  <= 12'd0;
      s1_col_q  <= ColR;
      s1_gain_q <= 8'd0;
      s1_byp_q  <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_raw_q  <= data_in[15:4];
        s1_col_q  <= pix_col;
        s1_gain_q <= pix_gain;
        s1_byp_q  <= byp_q;
      end
    end
  end

  assign s1_fire = s1_vld_q & en_q;
  assign prod    = {8'd0, s1_raw_q} * {12'd0, s1_gain_q};
  assign scaled  = prod[19:4];
  assign sat     = (|scaled[15:12]) ? 12'hFFF : scaled[11:0];

  // Stage 2: gain and saturate into the matching hold register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      s2_vld_q <= 1'b0;
      s2_byp_q <= 1'b0;
      s2_raw_q <= 12'd0;
      hold_r_q <= 12'd0;
      hold_g_q <= 12'd0;
      hold_b_q <= 12'd0;
    end else begin
      s2_vld_q <= s1_fire;
      if (s1_fire) begin
        s2_byp_q <= s1_byp_q;
        s2_raw_q <= s1_raw_q;
        if (!s1_byp_q) begin
          case (s1_col_q)
            ColR:    hold_r_q <= sat;
            ColG:    hold_g_q <= sat;
            default: hold_b_q <= sat;
          endcase
        end
      end
    end
  end

  assign s2_fire = s2_vld_q & en_q;

  // Output pack: grey replicate in bypass, otherwise the three held colours
  always_comb begin
    rgb_d = rgb_q;
    if (s2_fire) begin
      if (s2_byp_q) begin
        rgb_d = {s2_raw_q[11:7], s2_raw_q[11:6], s2_raw_q[11:7]};
      end else begin
        rgb_d = {hold_r_q[11:7], hold_g_q[11:6], hold_b_q[11:7]};
      end
    end
  end

  // Stage 3: output register, data held between valid pulses
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rgb_q     <= 16'd0;
      dout_en_q <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      dout_en_q <= s2_fire;
    end
  end

  assign rgb_data_out = rgb_q;
  assign DoutEn       = dout_en_q;
  assign frames_cnt   = frames_q;

endmodule

// File: tb/tb_ahb_isp_sys.sv
`timescale 1ns/1ps
// Bench for ahb_isp_sys: register vectors, single-pixel vectors, frame counting,
// randomised streams against a reference model, and mid-stream reset.
module tb_ahb_isp_sys;

  logic        HCLK, HRESETn;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HREADY, HWRITE, HSEL, HREADYOUT;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [15:0] data_in, rgb_data_out, frames_cnt;
  logic        fifo_empty, DoutEn;

  ahb_isp_sys #(.LPF_W(10), .FCNT_W(16)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HWRITE      (HWRITE),
    .HTRANS      (HTRANS),
    .HSEL        (HSEL),
    .HSIZE       (HSIZE),
    .HRDATA      (HRDATA),
    .HREADYOUT   (HREADYOUT),
    .data_in     (data_in),
    .fifo_empty  (fifo_empty),
    .rgb_data_out(rgb_data_out),
    .DoutEn      (DoutEn),
    .frames_cnt  (frames_cnt)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } reg_vec_t;

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] wb;
    logic [31:0] cfg;
    logic [11:0] raw;
    logic [15:0] exp;
  } pix_vec_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_en, m_byp, m_prev;
  logic [31:0] m_wb;
  int          m_lpf, m_cfg, m_x, m_y, m_lines, m_frames;
  int          m_hold[3];
  logic [15:0] m_last;
  exp_t        exp_q[$];
  int          cyc;

  bit          pend_we;
  logic [31:0] pend_addr, pend_data;

  int          pulses;
  logic [15:0] last_out;
  logic [15:0] got_q[$];

  reg_vec_t reg_tab[10];
  pix_vec_t pix_tab[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int colour_of(int p, int y, int x);
    string s;
    byte   c;
    case (p)
      0:       s = "RGGB";
      1:       s = "GRBG";
      2:       s = "GBRG";
      default: s = "BGGR";
    endcase
    c = s.getc(y * 2 + x);
    if (c == "R") return 0;
    if (c == "G") return 1;
    return 2;
  endfunction

  function automatic int sat_gain(int raw, int gain);
    int v;
    v = (raw * gain) / 16;
    return (v > 4095) ? 4095 : v;
  endfunction

  function automatic logic [15:0] pack(int r, int g, int b);
    return {5'(r / 128), 6'(g / 64), 5'(b / 128)};
  endfunction

  task automatic model_reset();
    m_en = 0; m_byp = 0; m_prev = 0;
    m_wb = 32'd0;
    m_lpf = 0; m_cfg = 0; m_x = 0; m_y = 0; m_lines = 0; m_frames = 0;
    m_hold[0] = 0; m_hold[1] = 0; m_hold[2] = 0;
    m_last = 16'd0;
    exp_q.delete();
    pend_we = 0;
  endtask

  // One clock: drive pixel inputs, advance model, tick, then compare outputs
  task automatic cycle(input bit v, input logic [11:0] raw);
    int px, col, gain, lim;
    logic [15:0] out;
    bit expv;
    exp_t e;
    fifo_empty = ~v;
    data_in    = {raw, 4'($urandom)};
    if (m_en) begin
      if (v) begin
        px  = m_prev ? m_x : 0;
        col = colour_of(m_cfg, m_y, px);
        if (m_byp) begin
          out = pack(int'(raw), int'(raw), int'(raw));
        end else begin
          gain = int'((m_wb >> (8 * col)) & 32'hFF);
          m_hold[col] = sat_gain(int'(raw), gain);
          out = pack(m_hold[0], m_hold[1], m_hold[2]);
        end
        e.due  = cyc + 3;
        e.data = out;
        exp_q.push_back(e);
        m_x = 1 - px;
      end else if (m_prev) begin
        m_lines++;
        m_y = 1 - m_y;
        lim = (m_lpf == 0) ? 1024 : m_lpf;
        if (m_lines == lim) begin
          m_lines  = 0;
          m_y      = 0;
          m_frames = (m_frames + 1) % 65536;
        end
      end
      m_prev = v;
    end
    @(posedge HCLK);
    #1;
    cyc++;
    if (pend_we) begin
      case (pend_addr[4:2])
        3'd0: begin
          m_byp = pend_data[0];
          m_en  = pend_data[2];
          if (pend_data[1]) m_frames = 0;
        end
        3'd1: m_wb  = pend_data;
        3'd2: m_lpf = int'(pend_data[9:0]);
        3'd3: m_cfg = int'(pend_data[1:0]);
        default: ;
      endcase
      pend_we = 0;
    end
    expv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("dout_en", 32'(DoutEn), 32'(expv));
    if (expv) begin
      m_last = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    check("rgb_data_out", 32'(rgb_data_out), 32'(m_last));
    check("frames_cnt", 32'(frames_cnt), m_frames);
    check("hreadyout", 32'(HREADYOUT), 32'd1);
    if (DoutEn === 1'b1) begin
      pulses++;
      last_out = rgb_data_out;
      got_q.push_back(rgb_data_out);
    end
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    cycle(1'b0, 12'd0);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = $urandom; HWDATA = data;
    pend_we = 1; pend_addr = addr; pend_data = data;
    cycle(1'b0, 12'd0);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    cycle(1'b0, 12'd0);
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = $urandom;
    data = HRDATA;
    cycle(1'b0, 12'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int p0;
    bit v;

    reg_tab[0] = '{32'h0,  32'h4,        32'h4};
    reg_tab[1] = '{32'h4,  32'h10015010, 32'h10015010};
    reg_tab[2] = '{32'h8,  32'h8899AA00, 32'h8899AA00};
    reg_tab[3] = '{32'hC,  32'h2,        32'h2};
    reg_tab[4] = '{32'hC,  32'hFFFFFFFF, 32'h3};
    reg_tab[5] = '{32'h0,  32'h7,        32'h5};
    reg_tab[6] = '{32'h10, 32'h1234,     32'h0};
    reg_tab[7] = '{32'h14, 32'hDEADBEEF, 32'h0};
    reg_tab[8] = '{32'h1C, 32'hFFFFFFFF, 32'h0};
    reg_tab[9] = '{32'h0,  32'h0,        32'h0};

    // One-pixel lines with LPF=1, so every pixel sits at (0,0); holds carry over
    pix_tab[0] = '{32'h4, 32'h00101010, 32'h0, 12'h800, 16'h8000};
    pix_tab[1] = '{32'h4, 32'h00101050, 32'h0, 12'h800, 16'hF800};
    pix_tab[2] = '{32'h4, 32'h00101010, 32'h1, 12'h400, 16'hFA00};
    pix_tab[3] = '{32'h4, 32'h00201010, 32'h3, 12'h300, 16'hFA0C};
    pix_tab[4] = '{32'h5, 32'h00201010, 32'h3, 12'hFFF, 16'hFFFF};
    pix_tab[5] = '{32'h5, 32'h00201010, 32'h0, 12'h000, 16'h0000};
    pix_tab[6] = '{32'h4, 32'h00101008, 32'h2, 12'hFFF, 16'hFFEC};
    pix_tab[7] = '{32'h4, 32'h00101008, 32'h0, 12'h802, 16'h47EC};

    HRESETn = 1'b0; HADDR = 32'd0; HWDATA = 32'd0; HREADY = 1'b1; HWRITE = 1'b0;
    HTRANS = 2'b00; HSEL = 1'b0; HSIZE = 3'b010; data_in = 16'd0; fifo_empty = 1'b1;
    pulses = 0; last_out = 16'd0; cyc = 0;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1;
    check("reset_dout_en", 32'(DoutEn), 32'd0);
    check("reset_rgb", 32'(rgb_data_out), 32'd0);
    check("reset_frames", 32'(frames_cnt), 32'd0);
    check("reset_hreadyout", 32'(HREADYOUT), 32'd1);
    check("reset_hrdata", HRDATA, 32'd0);
    HRESETn = 1'b1;

    // Register write/readback vectors
    for (int i = 0; i < 10; i++) begin
      ahb_write(reg_tab[i].addr, reg_tab[i].wdata);
      ahb_read(reg_tab[i].addr, rd);
      check($sformatf("reg_rd[%0d]", i), rd, reg_tab[i].rexp);
    end

    // Single-pixel vectors
    ahb_write(32'h8, 32'h1);
    for (int i = 0; i < 8; i++) begin
      ahb_write(32'h0, pix_tab[i].ctrl);
      ahb_write(32'h4, pix_tab[i].wb);
      ahb_write(32'hC, pix_tab[i].cfg);
      p0 = pulses;
      cycle(1'b1, pix_tab[i].raw);
      repeat (4) cycle(1'b0, 12'd0);
      check($sformatf("vec_pulses[%0d]", i), pulses - p0, 32'd1);
      check($sformatf("vec_out[%0d]", i), 32'(last_out), 32'(pix_tab[i].exp));
    end

    // Frame counting: LPF=2, six 21-pixel lines, then clear while enabled
    ahb_write(32'h0, 32'h6);
    ahb_write(32'h4, 32'h00101010);
    ahb_write(32'hC, 32'h0);
    ahb_write(32'h8, 32'h2);
    for (int l = 0; l < 6; l++) begin
      for (int p = 0; p < 21; p++) cycle(1'b1, 12'($urandom));
      cycle(1'b0, 12'd0);
    end
    repeat (3) cycle(1'b0, 12'd0);
    check("frames_after_6_lines", 32'(frames_cnt), 32'd3);
    ahb_write(32'h0, 32'h6);
    check("frames_after_clear", 32'(frames_cnt), 32'd0);
    ahb_read(32'h10, rd);
    check("stat_after_clear", rd, 32'd0);

    // Randomised streams against the model
    ahb_write(32'h8, 32'h3);
    for (int r = 0; r < 10; r++) begin
      ahb_write(32'h4, $urandom);
      ahb_write(32'hC, 32'($urandom_range(0, 3)));
      ahb_write(32'h0, {29'd0, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) == 0),
                        1'($urandom_range(0, 3) == 0)});
      for (int k = 0; k < 60; k++) begin
        v = ($urandom_range(0, 3) != 0);
        cycle(v, 12'($urandom));
      end
      repeat (4) cycle(1'b0, 12'd0);
    end
    ahb_read(32'h10, rd);
    check("stat_random", rd, 32'(m_frames));

    // Reset in the middle of a line with pixels in flight
    ahb_write(32'h0, 32'h4);
    ahb_write(32'h4, 32'h00101010);
    ahb_write(32'hC, 32'h0);
    ahb_write(32'h8, 32'h0);
    cycle(1'b1, 12'h100);
    cycle(1'b1, 12'h200);
    cycle(1'b1, 12'h300);
    fifo_empty = 1'b0;
    data_in    = 16'h4440;
    HRESETn    = 1'b0;
    @(posedge HCLK);
    #1;
    cyc++;
    HRESETn    = 1'b1;
    fifo_empty = 1'b1;
    model_reset();
    check("midrst_dout_en", 32'(DoutEn), 32'd0);
    check("midrst_rgb", 32'(rgb_data_out), 32'd0);
    check("midrst_frames", 32'(frames_cnt), 32'd0);
    for (int a = 0; a < 4; a++) begin
      ahb_read(32'(a * 4), rd);
      check($sformatf("midrst_reg[%0d]", a), rd, 32'd0);
    end

    // Restarted line begins at R (RGGB): 0x800 then 0x400
    ahb_write(32'h0, 32'h4);
    ahb_write(32'h4, 32'h00101010);
    got_q.delete();
    cycle(1'b1, 12'h800);
    cycle(1'b1, 12'h400);
    repeat (4) cycle(1'b0, 12'd0);
    check("restart_count", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      check("restart_first", 32'(got_q[0]), 32'h8000);
      check("restart_second", 32'(got_q[1]), 32'h8200);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
